// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: unit-size codes, default widths,
// grant-owner encoding and the fixed-priority owner selection.
package dmem_arbiter_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_LEN  = 32;

  localparam logic [2:0] FUNCT3_BYTE  = 3'b000;
  localparam logic [2:0] FUNCT3_HALF  = 3'b001;
  localparam logic [2:0] FUNCT3_WORD  = 3'b010;
  localparam logic [2:0] FUNCT3_BYTEU = 3'b100;
  localparam logic [2:0] FUNCT3_HALFU = 3'b101;

  typedef enum logic [1:0] {
    ARB_OWNER_NONE = 2'd0,
    ARB_OWNER_CORE = 2'd1,
    ARB_OWNER_DBG  = 2'd2
  } arb_owner_e;

  // Lock and starvation override win over the core; the core otherwise wins over dbg.
  function automatic arb_owner_e arb_select(input logic lock_held,
                                            input logic wait_hit,
                                            input logic core_req,
                                            input logic dbg_req);
    if (lock_held && dbg_req)     return ARB_OWNER_DBG;
    else if (dbg_req && wait_hit) return ARB_OWNER_DBG;
    else if (core_req)            return ARB_OWNER_CORE;
    else if (dbg_req)             return ARB_OWNER_DBG;
    else                          return ARB_OWNER_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module dmem_arbiter_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core MEM stage and the debug port,
// with bounded dbg starvation, a dbg lock for atomic sequences and registered read data.
module dmem_arbiter #(
  parameter int ADDR_SIZE = dmem_arbiter_pkg::ADDR_SIZE,
  parameter int WORD_LEN  = dmem_arbiter_pkg::WORD_LEN,
  parameter int MAX_WAIT  = 4,
  parameter int LOCK_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 coreReq,
  input  logic                 coreWe,
  input  logic [ADDR_SIZE-1:0] coreAddr,
  input  logic [2:0]           coreSize,
  input  logic [WORD_LEN-1:0]  coreWdata,
  input  logic                 dbgReq,
  input  logic                 dbgWe,
  input  logic [ADDR_SIZE-1:0] dbgAddr,
  input  logic [2:0]           dbgSize,
  input  logic [WORD_LEN-1:0]  dbgWdata,
  input  logic                 dbgLock,
  output logic                 coreGnt,
  output logic                 dbgGnt,
  output logic                 coreRvalid,
  output logic                 dbgRvalid,
  output logic [WORD_LEN-1:0]  coreRdata,
  output logic [WORD_LEN-1:0]  dbgRdata,
  output logic                 memWe,
  output logic [ADDR_SIZE-1:0] memAddr,
  output logic [2:0]           memSize,
  output logic [WORD_LEN-1:0]  memWdata,
  input  logic [WORD_LEN-1:0]  memRdata
);

  import dmem_arbiter_pkg::*;

  arb_owner_e          owner;
  logic [3:0]          wait_cnt;
  logic [3:0]          lock_cnt;
  logic                lock_held;
  logic                wait_hit;
  logic                lock_room;
  logic                lock_set;
  logic                lock_clr;
  logic                core_rd;
  logic                dbg_rd;
  logic                core_vld_p1;
  logic                dbg_vld_p1;
  logic [WORD_LEN-1:0] core_rdata_p1;
  logic [WORD_LEN-1:0] dbg_rdata_p1;

  assign wait_hit  = (wait_cnt == 4'(MAX_WAIT));
  assign lock_room = (lock_cnt < 4'(LOCK_MAX - 1));

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    owner = ARB_OWNER_NONE;
    if (rstN) begin
      owner = arb_select(lock_held, wait_hit, coreReq, dbgReq);
    end
  end

  assign coreGnt = (owner == ARB_OWNER_CORE);
  assign dbgGnt  = (owner == ARB_OWNER_DBG);

  always_comb begin
    memWe    = 1'b0;
    memAddr  = '0;
    memSize  = FUNCT3_WORD;
    memWdata = '0;
    case (owner)
      ARB_OWNER_CORE: begin
        memWe    = coreWe;
        memAddr  = coreAddr;
        memSize  = coreSize;
        memWdata = coreWdata;
      end
      ARB_OWNER_DBG: begin
        memWe    = dbgWe;
        memAddr  = dbgAddr;
        memSize  = dbgSize;
        memWdata = dbgWdata;
      end
      default: ;
    endcase
  end

  dmem_arbiter_sat_counter #(
    .W   (4),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rstN),
    .clr   (dbgGnt || !dbgReq),
    .inc   (dbgReq && !dbgGnt),
    .count (wait_cnt)
  );

  // The final permitted locked grant releases the lock so the core gets the next cycle.
  assign lock_set = dbgGnt && dbgLock && lock_room;
  assign lock_clr = dbgGnt ? !lock_set : !dbgReq;

  dmem_arbiter_sat_counter #(
    .W   (4),
    .MAX (LOCK_MAX - 1)
  ) u_lock_cnt (
    .clk   (clk),
    .rst_n (rstN),
    .clr   (lock_clr),
    .inc   (lock_set),
    .count (lock_cnt)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lock_held <= 1'b0;
    end else if (lock_set) begin
      lock_held <= 1'b1;
    end else if (lock_clr) begin
      lock_held <= 1'b0;
    end
  end

  // ---- stage p0 -> p1: registered read response ----
  assign core_rd = coreGnt && !coreWe;
  assign dbg_rd  = dbgGnt && !dbgWe;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      core_vld_p1   <= 1'b0;
      dbg_vld_p1    <= 1'b0;
      core_rdata_p1 <= '0;
      dbg_rdata_p1  <= '0;
    end else begin
      core_vld_p1 <= core_rd;
      dbg_vld_p1  <= dbg_rd;
      if (core_rd) core_rdata_p1 <= memRdata;
      if (dbg_rd)  dbg_rdata_p1  <= memRdata;
    end
  end

  assign coreRvalid = core_vld_p1;
  assign dbgRvalid  = dbg_vld_p1;
  assign coreRdata  = core_rdata_p1;
  assign dbgRdata   = dbg_rdata_p1;

  a_one_grant : assert property (@(posedge clk) disable iff (!rstN) !(coreGnt && dbgGnt));

endmodule
